// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
// Widths, FSM encoding and master indices.
package sram_arb_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the SRAM.
// slave = arbiter view, master = environment view.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int DW = sram_arb_pkg::DATA_WIDTH,
  parameter int AW = sram_arb_pkg::ADDR_WIDTH
);

  logic          m0_req;
  logic          m0_we_n;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we_n;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_we_n;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  m0_req,
    input  m0_we_n,
    input  m0_addr,
    input  m0_wdata,
    output m0_ack,
    output m0_rdata,
    input  m1_req,
    input  m1_we_n,
    input  m1_addr,
    input  m1_wdata,
    output m1_ack,
    output m1_rdata,
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    input  sram_rdata
  );

  modport master (
    output m0_req,
    output m0_we_n,
    output m0_addr,
    output m0_wdata,
    input  m0_ack,
    input  m0_rdata,
    output m1_req,
    output m1_we_n,
    output m1_addr,
    output m1_wdata,
    input  m1_ack,
    input  m1_rdata,
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    output sram_rdata
  );

endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// On a tie the master that did not win last time is chosen.
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  // pick a winner from the current requests
  always_comb begin
    valid = |req;
    grant = M_CPU;
    unique case (1'b1)
      (req == 2'b11): grant = ~last_grant;
      (req == 2'b10): grant = M_LDR;
      default:        grant = M_CPU;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the cpu (m0) and loader (m1).
// Each access runs IDLE -> ACCESS -> DONE, ack pulses in DONE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH
)(
  input  logic              clk,
  input  logic              reset_n,
  sram_arbiter_if.slave     bus
);

  state_t                  state_q;
  state_t                  state_d;

  logic                    sel_q;
  logic                    last_grant_q;

  logic                    pick_valid;
  logic                    pick_grant;

  logic                    load;
  logic                    drop_we;
  logic                    clear;

  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    win_we_n;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_n_q;

  logic                    done;
  logic                    ack0;
  logic                    ack1;

  rr_pick2 u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // steer the winning master's request onto the latch inputs
  always_comb begin
    win_addr  = bus.m0_addr;
    win_wdata = bus.m0_wdata;
    win_we_n  = bus.m0_we_n;
    if (pick_grant == M_LDR) begin
      win_addr  = bus.m1_addr;
      win_wdata = bus.m1_wdata;
      win_we_n  = bus.m1_we_n;
    end
  end

  // state register; reset drops straight back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and datapath control strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop_we = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          load    = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        drop_we = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // grant bookkeeping, updated only when a grant is made
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q        <= M_CPU;
      last_grant_q <= M_LDR;
    end else if (load) begin
      sel_q        <= pick_grant;
      last_grant_q <= pick_grant;
    end
  end

  // SRAM-side registers; write strobe lives only for the ACCESS cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
    end else begin
      if (load) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        we_n_q  <= win_we_n;
      end
      if (drop_we) begin
        we_n_q  <= 1'b1;
      end
      if (clear) begin
        addr_q  <= '0;
        wdata_q <= '0;
      end
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we_n  = we_n_q;

  // ack and read data go only to the master that owns the access
  always_comb begin
    done         = (state_q == ST_DONE);
    ack0         = done && (sel_q == M_CPU);
    ack1         = done && (sel_q == M_LDR);
    bus.m0_ack   = ack0;
    bus.m1_ack   = ack1;
    bus.m0_rdata = '0;
    bus.m1_rdata = '0;
    if (ack0) begin
      bus.m0_rdata = bus.sram_rdata;
    end
    if (ack1) begin
      bus.m1_rdata = bus.sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a registered-read SRAM model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sram_arbiter_if bif ();

  sram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  logic [15:0] mem [0:255];
  logic [15:0] rd_q;

  always @(posedge clk) begin
    if (!bif.sram_we_n) mem[bif.sram_addr[7:0]] <= bif.sram_wdata;
    rd_q <= mem[bif.sram_addr[7:0]];
  end

  assign bif.sram_rdata = rd_q;

  int total  = 0;
  int passed = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_outs(string tag);
    chk1 ({tag, ".we_n"},   bif.sram_we_n,  1'b1);
    chk16({tag, ".addr"},   bif.sram_addr,  16'h0000);
    chk16({tag, ".wdata"},  bif.sram_wdata, 16'h0000);
    chk1 ({tag, ".ack0"},   bif.m0_ack,     1'b0);
    chk1 ({tag, ".ack1"},   bif.m1_ack,     1'b0);
    chk16({tag, ".rdata0"}, bif.m0_rdata,   16'h0000);
    chk16({tag, ".rdata1"}, bif.m1_rdata,   16'h0000);
  endtask

  task automatic set_m0(logic r, logic w, logic [15:0] a, logic [15:0] d);
    bif.m0_req = r; bif.m0_we_n = w; bif.m0_addr = a; bif.m0_wdata = d;
  endtask

  task automatic set_m1(logic r, logic w, logic [15:0] a, logic [15:0] d);
    bif.m1_req = r; bif.m1_we_n = w; bif.m1_addr = a; bif.m1_wdata = d;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic        exp_w;
  logic [15:0] exp_d;
  logic [15:0] b2b_a [0:2];
  logic [15:0] b2b_d [0:2];

  initial begin
    reset_n = 1'b1;
    set_m0(1'b0, 1'b1, 16'h0, 16'h0);
    set_m1(1'b0, 1'b1, 16'h0, 16'h0);

    // reset asserted mid-clock, outputs settle before any edge
    tick;
    #2 reset_n = 1'b0;
    #1 idle_outs("rst");
    tick;
    reset_n = 1'b1;
    tick;
    idle_outs("post_rst");

    // m0 write 0x0010 = 0xBEEF
    set_m0(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    chk1("wr.idle.we_n", bif.sram_we_n, 1'b1);
    tick;
    chk1 ("wr.acc.we_n",  bif.sram_we_n,  1'b0);
    chk16("wr.acc.addr",  bif.sram_addr,  16'h0010);
    chk16("wr.acc.wdata", bif.sram_wdata, 16'hBEEF);
    chk1 ("wr.acc.ack0",  bif.m0_ack,     1'b0);
    tick;
    chk1 ("wr.done.we_n", bif.sram_we_n,  1'b1);
    chk1 ("wr.done.ack0", bif.m0_ack,     1'b1);
    chk1 ("wr.done.ack1", bif.m1_ack,     1'b0);
    chk16("wr.done.rd1",  bif.m1_rdata,   16'h0000);
    set_m0(1'b0, 1'b1, 16'h0, 16'h0);
    tick;
    idle_outs("wr.after");

    // m0 read 0x0010
    set_m0(1'b1, 1'b1, 16'h0010, 16'h0);
    tick;
    chk1 ("rd.acc.we_n",  bif.sram_we_n, 1'b1);
    chk16("rd.acc.addr",  bif.sram_addr, 16'h0010);
    tick;
    chk1 ("rd.done.ack0", bif.m0_ack,    1'b1);
    chk16("rd.done.rd0",  bif.m0_rdata,  16'hBEEF);
    set_m0(1'b0, 1'b1, 16'h0, 16'h0);
    tick;
    chk1 ("rd.after.ack0", bif.m0_ack, 1'b0);

    // fresh reset, then a tie: m0 writes 0x0040, m1 writes 0x0020
    #2 reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    set_m0(1'b1, 1'b0, 16'h0040, 16'h5555);
    set_m1(1'b1, 1'b0, 16'h0020, 16'h1234);
    tick;
    chk16("tie.acc0.addr", bif.sram_addr, 16'h0040);
    chk1 ("tie.acc0.we_n", bif.sram_we_n, 1'b0);
    tick;
    chk1 ("tie.done0.ack0", bif.m0_ack, 1'b1);
    chk1 ("tie.done0.ack1", bif.m1_ack, 1'b0);
    set_m0(1'b0, 1'b1, 16'h0, 16'h0);
    tick;
    chk1 ("tie.idle.ack0", bif.m0_ack, 1'b0);
    chk1 ("tie.idle.ack1", bif.m1_ack, 1'b0);
    tick;
    chk16("tie.acc1.addr",  bif.sram_addr,  16'h0020);
    chk16("tie.acc1.wdata", bif.sram_wdata, 16'h1234);
    chk1 ("tie.acc1.ack1",  bif.m1_ack,     1'b0);
    tick;
    chk1 ("tie.done1.ack1", bif.m1_ack, 1'b1);
    chk1 ("tie.done1.ack0", bif.m0_ack, 1'b0);
    set_m1(1'b0, 1'b1, 16'h0, 16'h0);
    tick;
    idle_outs("tie.after");

    // fairness: both hold read requests for six accesses
    set_m0(1'b1, 1'b1, 16'h0010, 16'h0);
    set_m1(1'b1, 1'b1, 16'h0020, 16'h0);
    for (int i = 0; i < 6; i++) begin
      exp_w = (i % 2 == 1);
      chk1 ("fair.idle.ack0", bif.m0_ack,   1'b0);
      chk1 ("fair.idle.ack1", bif.m1_ack,   1'b0);
      chk16("fair.idle.rd1",  bif.m1_rdata, 16'h0000);
      tick;
      chk16("fair.acc.addr", bif.sram_addr, exp_w ? 16'h0020 : 16'h0010);
      chk16("fair.acc.rd1",  bif.m1_rdata,  16'h0000);
      tick;
      chk1("fair.done.ack0", bif.m0_ack, ~exp_w);
      chk1("fair.done.ack1", bif.m1_ack, exp_w);
      if (exp_w) begin
        chk16("fair.done.rd1", bif.m1_rdata, 16'h1234);
        chk16("fair.done.rd0", bif.m0_rdata, 16'h0000);
      end else begin
        chk16("fair.done.rd0", bif.m0_rdata, 16'hBEEF);
        chk16("fair.done.rd1", bif.m1_rdata, 16'h0000);
      end
      if (i == 5) begin
        set_m0(1'b0, 1'b1, 16'h0, 16'h0);
        set_m1(1'b0, 1'b1, 16'h0, 16'h0);
      end
      tick;
    end
    idle_outs("fair.after");

    // abandoned write: reset lands during ACCESS
    set_m1(1'b1, 1'b0, 16'h0030, 16'hAAAA);
    tick;
    chk1 ("abn.acc.we_n", bif.sram_we_n, 1'b0);
    chk16("abn.acc.addr", bif.sram_addr, 16'h0030);
    #2 reset_n = 1'b0;
    #1;
    chk1 ("abn.rst.we_n", bif.sram_we_n, 1'b1);
    chk16("abn.rst.addr", bif.sram_addr, 16'h0000);
    chk1 ("abn.rst.ack1", bif.m1_ack,    1'b0);
    set_m1(1'b0, 1'b1, 16'h0, 16'h0);
    tick;
    reset_n = 1'b1;
    idle_outs("abn.held");
    tick;
    idle_outs("abn.idle");

    // other data survives: m0 read of 0x0020
    set_m0(1'b1, 1'b1, 16'h0020, 16'h0);
    tick;
    chk16("abn.rd.addr", bif.sram_addr, 16'h0020);
    tick;
    chk1 ("abn.rd.ack0", bif.m0_ack,   1'b1);
    chk16("abn.rd.rd0",  bif.m0_rdata, 16'h1234);
    set_m0(1'b0, 1'b1, 16'h0, 16'h0);
    tick;

    // back-to-back reads by m1, req held across each ack
    b2b_a[0] = 16'h0010; b2b_d[0] = 16'hBEEF;
    b2b_a[1] = 16'h0020; b2b_d[1] = 16'h1234;
    b2b_a[2] = 16'h0040; b2b_d[2] = 16'h5555;
    set_m1(1'b1, 1'b1, b2b_a[0], 16'h0);
    for (int i = 0; i < 3; i++) begin
      exp_d = b2b_d[i];
      chk1 ("b2b.idle.ack1", bif.m1_ack, 1'b0);
      tick;
      chk16("b2b.acc.addr",  bif.sram_addr, b2b_a[i]);
      chk1 ("b2b.acc.ack0",  bif.m0_ack,    1'b0);
      tick;
      chk1 ("b2b.done.ack1", bif.m1_ack,    1'b1);
      chk1 ("b2b.done.ack0", bif.m0_ack,    1'b0);
      chk16("b2b.done.rd1",  bif.m1_rdata,  exp_d);
      if (i < 2) set_m1(1'b1, 1'b1, b2b_a[i+1], 16'h0);
      else       set_m1(1'b0, 1'b1, 16'h0, 16'h0);
      tick;
    end
    idle_outs("b2b.after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
